// File: rtl/execute.sv
// Execute stage: ALU, EX pipeline register and a 32-iteration multiply/divide unit with HI/LO.
// Define MDU_DIV_EN to build the divider; without it div/divu behave as no-ops.
module execute (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        AnyStall,
    input  logic [31:0] SrcA_DE,
    input  logic [31:0] SrcB_DE,
    input  logic [31:0] RtDat_DE,
    input  logic [2:0]  AluCtl_DE,
    input  logic [2:0]  MdOp_DE,
    input  logic        RegWrite_DE,
    input  logic        MemToReg_DE,
    input  logic        MemWrite_DE,
    input  logic [4:0]  WriteReg_DE,
    output logic [31:0] Result_EX,
    output logic [31:0] WrDat_EX,
    output logic        RegWrite_EX,
    output logic        MemToReg_EX,
    output logic        MemWrite_EX,
    output logic [4:0]  WriteReg_EX,
    output logic        MdStall_EX,
    output logic        MdBusy_EX
);
    localparam int unsigned DataW = 32;
    localparam int unsigned CntW  = 6;
    localparam logic [CntW-1:0] IterLast = CntW'(DataW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MDU_DIV_EN
        DIV  = 2'd2,
`endif
        DONE = 2'd3
    } mdState_t;

    mdState_t           state, stateNext;
    logic [CntW-1:0]    cnt, cntNext;
    logic [2*DataW-1:0] acc, accNext, prod;
    logic [DataW-1:0]   opReg, hi, lo, hiRes, loRes, aluOut, aMag, bMag;
    logic [DataW:0]     mulSum;
    logic               negQ, aNeg, bNeg, isMul, isDiv, isSigned, divIgnored, issue;
`ifdef MDU_DIV_EN
    logic               negR, isDivReg, divZero, divGe;
    logic [DataW-1:0]   dividend;
    logic [DataW:0]     divShift, divDiff;
`endif

    // Operation decode and operand magnitudes; the MDU works on magnitudes and fixes signs at the end.
    always_comb begin
        isMul    = (MdOp_DE == 3'b001) || (MdOp_DE == 3'b010);
        isSigned = (MdOp_DE == 3'b001) || (MdOp_DE == 3'b011);
`ifdef MDU_DIV_EN
        isDiv      = (MdOp_DE == 3'b011) || (MdOp_DE == 3'b100);
        divIgnored = 1'b0;
`else
        isDiv      = 1'b0;
        divIgnored = (MdOp_DE == 3'b011) || (MdOp_DE == 3'b100);
`endif
        aNeg = isSigned && SrcA_DE[DataW-1];
        bNeg = isSigned && SrcB_DE[DataW-1];
        aMag = aNeg ? -SrcA_DE : SrcA_DE;
        bMag = bNeg ? -SrcB_DE : SrcB_DE;
    end

    assign MdStall_EX = MdBusy_EX && (MdOp_DE != 3'b000) && !divIgnored;
    assign issue      = (state == IDLE) && (isMul || isDiv) && !AnyStall && !MdStall_EX;

    always_comb begin
        aluOut = '0;
        case (AluCtl_DE)
            3'b000:  aluOut = SrcA_DE & SrcB_DE;
            3'b001:  aluOut = SrcA_DE | SrcB_DE;
            3'b010:  aluOut = SrcA_DE + SrcB_DE;
            3'b011:  aluOut = DataW'(SrcA_DE < SrcB_DE);
            3'b100:  aluOut = SrcA_DE ^ SrcB_DE;
            3'b110:  aluOut = SrcA_DE - SrcB_DE;
            3'b111:  aluOut = DataW'($signed(SrcA_DE) < $signed(SrcB_DE));
            default: aluOut = '0;
        endcase
    end

    // MDU next state: one shift-add or restoring-divide step per edge, then one spare edge into DONE.
    always_comb begin
        mulSum    = {1'b0, acc[2*DataW-1:DataW]} + (acc[0] ? {1'b0, opReg} : '0);
`ifdef MDU_DIV_EN
        divShift  = {acc[2*DataW-1:DataW], acc[DataW-1]};
        divGe     = divShift >= {1'b0, opReg};
        divDiff   = divShift - {1'b0, opReg};
`endif
        stateNext = state;
        cntNext   = cnt;
        accNext   = acc;
        case (state)
            IDLE: begin
                if (issue) begin
                    cntNext = '0;
                    accNext = {{DataW{1'b0}}, isMul ? bMag : aMag};
`ifdef MDU_DIV_EN
                    stateNext = isDiv ? DIV : MUL;
`else
                    stateNext = MUL;
`endif
                end
            end
            MUL: begin
                if (cnt == IterLast) begin
                    stateNext = DONE;
                end else begin
                    accNext = {mulSum, acc[DataW-1:1]};
                    cntNext = cnt + CntW'(1);
                end
            end
`ifdef MDU_DIV_EN
            DIV: begin
                if (cnt == IterLast) begin
                    stateNext = DONE;
                end else begin
                    accNext = {divGe ? divDiff[DataW-1:0] : divShift[DataW-1:0], acc[DataW-2:0], divGe};
                    cntNext = cnt + CntW'(1);
                end
            end
`endif
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Sign correction and divide special cases applied when HI/LO are written.
    always_comb begin
        prod  = negQ ? -acc : acc;
        hiRes = prod[2*DataW-1:DataW];
        loRes = prod[DataW-1:0];
`ifdef MDU_DIV_EN
        if (isDivReg) begin
            if (divZero) begin
                hiRes = dividend;
                loRes = '1;
            end else begin
                hiRes = negR ? -acc[2*DataW-1:DataW] : acc[2*DataW-1:DataW];
                loRes = negQ ? -acc[DataW-1:0] : acc[DataW-1:0];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            MdBusy_EX <= 1'b0;
        end else begin
            state     <= stateNext;
            MdBusy_EX <= (stateNext != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opReg    <= '0;
            negQ     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MDU_DIV_EN
            negR     <= 1'b0;
            isDivReg <= 1'b0;
            divZero  <= 1'b0;
            dividend <= '0;
`endif
        end else begin
            cnt <= cntNext;
            acc <= accNext;
            if (issue) begin
                opReg    <= isMul ? aMag : bMag;
                negQ     <= aNeg ^ bNeg;
`ifdef MDU_DIV_EN
                negR     <= aNeg;
                isDivReg <= isDiv;
                divZero  <= (SrcB_DE == '0);
                dividend <= SrcA_DE;
`endif
            end
            if (state == DONE) begin
                hi <= hiRes;
                lo <= loRes;
            end
        end
    end

    // EX pipeline register; flush beats stall and never touches the MDU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            Result_EX   <= '0;
            WrDat_EX    <= '0;
            RegWrite_EX <= 1'b0;
            MemToReg_EX <= 1'b0;
            MemWrite_EX <= 1'b0;
            WriteReg_EX <= '0;
        end else if (!AnyStall) begin
            Result_EX   <= (MdOp_DE == 3'b101) ? hi : (MdOp_DE == 3'b110) ? lo : aluOut;
            WrDat_EX    <= RtDat_DE;
            RegWrite_EX <= RegWrite_DE;
            MemToReg_EX <= MemToReg_DE;
            MemWrite_EX <= MemWrite_DE;
            WriteReg_EX <= WriteReg_DE;
        end
    end
endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: cycle model of the EX register plus a countdown/arithmetic MDU model.
module tb_execute;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, extStall = 1'b0;
    logic        AnyStall;
    logic [31:0] SrcA_DE = '0, SrcB_DE = '0, RtDat_DE = '0;
    logic [2:0]  AluCtl_DE = '0, MdOp_DE = '0;
    logic        RegWrite_DE = 1'b0, MemToReg_DE = 1'b0, MemWrite_DE = 1'b0;
    logic [4:0]  WriteReg_DE = '0;
    logic [31:0] Result_EX, WrDat_EX;
    logic        RegWrite_EX, MemToReg_EX, MemWrite_EX, MdStall_EX, MdBusy_EX;
    logic [4:0]  WriteReg_EX;

    int nChecks = 0;
    int nFails  = 0;

    assign AnyStall = extStall | MdStall_EX;

    execute dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .AnyStall(AnyStall),
        .SrcA_DE(SrcA_DE), .SrcB_DE(SrcB_DE), .RtDat_DE(RtDat_DE),
        .AluCtl_DE(AluCtl_DE), .MdOp_DE(MdOp_DE),
        .RegWrite_DE(RegWrite_DE), .MemToReg_DE(MemToReg_DE), .MemWrite_DE(MemWrite_DE),
        .WriteReg_DE(WriteReg_DE),
        .Result_EX(Result_EX), .WrDat_EX(WrDat_EX),
        .RegWrite_EX(RegWrite_EX), .MemToReg_EX(MemToReg_EX), .MemWrite_EX(MemWrite_EX),
        .WriteReg_EX(WriteReg_EX), .MdStall_EX(MdStall_EX), .MdBusy_EX(MdBusy_EX)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] effOp(input logic [2:0] op);
`ifndef MDU_DIV_EN
        if (op == 3'b011 || op == 3'b100) return 3'b000;
`endif
        return op;
    endfunction

    function automatic logic [31:0] aluRef(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
        case (ctl)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return (a < b) ? 32'd1 : 32'd0;
            3'b100:  return a ^ b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Returns {HI, LO} for an MDU operation.
    function automatic logic [63:0] mduRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = a;
        ib = b;
        case (op)
            3'b001: return 64'(sa * sb);
            3'b010: return 64'(ua * ub);
            3'b011: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            3'b100: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Reference model: the MDU is a countdown of busy cycles with a precomputed result.
    int unsigned mCnt = 0;
    logic [63:0] mPend = '0;
    logic [31:0] mHi = '0, mLo = '0, eRes = '0, eWr = '0;
    logic        eRw = 1'b0, eM2r = 1'b0, eMw = 1'b0;
    logic [4:0]  eWreg = '0;
    logic [2:0]  eop;
    logic        mStall, mStallAll;

    assign eop       = effOp(MdOp_DE);
    assign mStall    = (mCnt != 0) && (eop != 3'b000);
    assign mStallAll = extStall | mStall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCnt <= 0; mPend <= '0; mHi <= '0; mLo <= '0;
            eRes <= '0; eWr <= '0; eRw <= 1'b0; eM2r <= 1'b0; eMw <= 1'b0; eWreg <= '0;
        end else begin
            if (flush) begin
                eRes <= '0; eWr <= '0; eRw <= 1'b0; eM2r <= 1'b0; eMw <= 1'b0; eWreg <= '0;
            end else if (!mStallAll) begin
                eRes  <= (eop == 3'b101) ? mHi : (eop == 3'b110) ? mLo : aluRef(AluCtl_DE, SrcA_DE, SrcB_DE);
                eWr   <= RtDat_DE;
                eRw   <= RegWrite_DE;
                eM2r  <= MemToReg_DE;
                eMw   <= MemWrite_DE;
                eWreg <= WriteReg_DE;
            end
            if (mCnt != 0) begin
                mCnt <= mCnt - 1;
                if (mCnt == 1) {mHi, mLo} <= mPend;
            end else if (!mStallAll && (eop inside {3'b001, 3'b010, 3'b011, 3'b100})) begin
                mCnt  <= 34;
                mPend <= mduRef(eop, SrcA_DE, SrcB_DE);
            end
        end
    end

    always @(negedge clk) begin
        check("Result_EX", Result_EX, eRes);
        check("WrDat_EX", WrDat_EX, eWr);
        check("RegWrite_EX", 32'(RegWrite_EX), 32'(eRw));
        check("MemToReg_EX", 32'(MemToReg_EX), 32'(eM2r));
        check("MemWrite_EX", 32'(MemWrite_EX), 32'(eMw));
        check("WriteReg_EX", 32'(WriteReg_EX), 32'(eWreg));
        check("MdBusy_EX", 32'(MdBusy_EX), 32'(mCnt != 0));
        check("MdStall_EX", 32'(MdStall_EX), 32'(mStall));
    end

    task automatic setAlu(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
        AluCtl_DE = ctl; SrcA_DE = a; SrcB_DE = b; MdOp_DE = 3'b000;
        RtDat_DE = 32'($urandom); RegWrite_DE = 1'b1; MemToReg_DE = 1'b0; MemWrite_DE = 1'b0;
        WriteReg_DE = 5'($urandom_range(0, 31));
    endtask

    task automatic setMd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        AluCtl_DE = 3'b010; SrcA_DE = a; SrcB_DE = b; MdOp_DE = op;
        RtDat_DE = 32'($urandom); RegWrite_DE = (op == 3'b101 || op == 3'b110);
        MemToReg_DE = 1'b0; MemWrite_DE = 1'b0; WriteReg_DE = 5'($urandom_range(0, 31));
    endtask

    // Called at negedge+1: holds mflo until the MDU releases it, then reads LO and HI.
    task automatic readHiLo(input string name, input logic [31:0] expLo, input logic [31:0] expHi, output int n);
        setMd(3'b110, 32'd0, 32'd0);
        #1;
        n = MdStall_EX ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!MdStall_EX) break;
            n++;
        end
        check({name, "_released"}, 32'(MdStall_EX), 32'd0);
        @(negedge clk);
        check({name, "_lo"}, Result_EX, expLo);
        #1 setMd(3'b101, 32'd0, 32'd0);
        @(negedge clk);
        check({name, "_hi"}, Result_EX, expHi);
        #1 setMd(3'b000, 32'd0, 32'd0);
    endtask

    task automatic mdSeq(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expLo, input logic [31:0] expHi);
        int n;
        setMd(op, a, b);
        @(negedge clk);
        check({name, "_busy"}, 32'(MdBusy_EX), 32'd1);
        #1 readHiLo(name, expLo, expHi, n);
        check({name, "_stall_cycles"}, 32'(n), 32'd34);
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 15));
            4:       return -32'($urandom_range(1, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [2:0] aluSel [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};

        repeat (2) @(negedge clk);
        check("reset_result", Result_EX, 32'd0);
        check("reset_busy", 32'(MdBusy_EX), 32'd0);
        #1 rst_n = 1'b1;

        setAlu(3'b110, 32'd5, 32'd7);
        @(negedge clk);
        check("sub_5_7", Result_EX, 32'hFFFFFFFE);
        #1 setAlu(3'b111, 32'd5, 32'd7);
        @(negedge clk);
        check("slt_5_7", Result_EX, 32'd1);
        #1 setAlu(3'b011, 32'hFFFFFFFF, 32'd1);
        @(negedge clk);
        check("sltu_max_1", Result_EX, 32'd0);
        #1;

        mdSeq("mult", 3'b001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'hFFFFFFFF);
        mdSeq("multu", 3'b010, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'd2);

        setAlu(3'b001, 32'h55, 32'd0);
        @(negedge clk);
        check("or_55", Result_EX, 32'h55);
        #1 setAlu(3'b010, 32'd1, 32'd2);
        extStall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall_hold", Result_EX, 32'h55);
        end
        #1 extStall = 1'b0;
        @(negedge clk);
        check("add_1_2", Result_EX, 32'd3);

        #1 setMd(3'b001, 32'd7, 32'd6);
        flush = 1'b1;
        @(negedge clk);
        check("flush_issue_result", Result_EX, 32'd0);
        check("flush_issue_busy", 32'(MdBusy_EX), 32'd1);
        #1 setAlu(3'b010, 32'd9, 32'd9);
        @(negedge clk);
        check("flush_mid_result", Result_EX, 32'd0);
        check("flush_mid_regwrite", 32'(RegWrite_EX), 32'd0);
        #1 flush = 1'b0;
        readHiLo("flush_mult", 32'd42, 32'd0, n);

        setMd(3'b001, 32'h12345678, 32'h9ABCDEF0);
        @(negedge clk);
        #1 setAlu(3'b001, 32'hAAAA0000, 32'h5555);
        MemWrite_DE = 1'b1;
        MemToReg_DE = 1'b1;
        @(negedge clk);
        #1 setMd(3'b110, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_result", Result_EX, 32'd0);
        check("arst_wrdat", WrDat_EX, 32'd0);
        check("arst_regwrite", 32'(RegWrite_EX), 32'd0);
        check("arst_memtoreg", 32'(MemToReg_EX), 32'd0);
        check("arst_memwrite", 32'(MemWrite_EX), 32'd0);
        check("arst_writereg", 32'(WriteReg_EX), 32'd0);
        check("arst_busy", 32'(MdBusy_EX), 32'd0);
        check("arst_stall", 32'(MdStall_EX), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        readHiLo("after_reset", 32'd0, 32'd0, n);

`ifdef MDU_DIV_EN
        mdSeq("div_m7_2", 3'b011, -32'd7, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        mdSeq("divu_7_0", 3'b100, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd7);
        mdSeq("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
`else
        mdSeq("multu_5_6", 3'b010, 32'd5, 32'd6, 32'd30, 32'd0);
        setMd(3'b011, 32'd9, 32'd3);
        @(negedge clk);
        check("div_ignored_busy", 32'(MdBusy_EX), 32'd0);
        #1 readHiLo("div_ignored", 32'd30, 32'd0, n);
        setMd(3'b001, 32'd1, 32'd1);
        @(negedge clk);
        #1 setMd(3'b011, 32'd9, 32'd3);
        #1 check("div_no_stall", 32'(MdStall_EX), 32'd0);
        readHiLo("mult_1_1", 32'd1, 32'd0, n);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            SrcA_DE     = randOperand();
            SrcB_DE     = randOperand();
            RtDat_DE    = 32'($urandom);
            AluCtl_DE   = aluSel[$urandom_range(0, 6)];
            MdOp_DE     = ($urandom_range(0, 99) < 75) ? 3'b000 : 3'($urandom_range(1, 6));
            RegWrite_DE = 1'($urandom);
            MemToReg_DE = 1'($urandom);
            MemWrite_DE = 1'($urandom);
            WriteReg_DE = 5'($urandom_range(0, 31));
            flush       = ($urandom_range(0, 19) == 0);
            extStall    = ($urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
